// File: rtl/coherence_pkg.sv
// Shared encodings for the MSI snooping coherence controller:
// line states, CPU actions and bus/snoop message opcodes.
package coherence_pkg;

    localparam logic [1:0] ST_INVALID   = 2'b00;
    localparam logic [1:0] ST_SHARED    = 2'b01;
    localparam logic [1:0] ST_EXCLUSIVE = 2'b10;

    localparam logic [2:0] ACT_NONE    = 3'b000;
    localparam logic [2:0] ACT_RD_HIT  = 3'b001;
    localparam logic [2:0] ACT_RD_MISS = 3'b010;
    localparam logic [2:0] ACT_WR_HIT  = 3'b011;
    localparam logic [2:0] ACT_WR_MISS = 3'b100;

    localparam logic [2:0] BUS_NONE    = 3'b000;
    localparam logic [2:0] BUS_RD_MISS = 3'b001;
    localparam logic [2:0] BUS_WR_MISS = 3'b010;
    localparam logic [2:0] BUS_INV     = 3'b011;

endpackage

// File: rtl/coherence_next_state.sv
// Combinational MSI transition function for a single cache line.
// Snoop and CPU are never selected together on one line (CPU stalls).
module coherence_next_state
    import coherence_pkg::*;
(
    input  logic [1:0] state,
    input  logic       cpu_sel,
    input  logic [2:0] cpu_action,
    input  logic       snoop_sel,
    input  logic [2:0] snoop_op,
    output logic [1:0] next_state,
    output logic [2:0] bus_op,
    output logic       writeback
);

    logic [1:0] cur;

    // Encoding 11 is illegal and behaves as Invalid when the line updates.
    assign cur = (state == 2'b11) ? ST_INVALID : state;

    // Snoop traffic takes priority; otherwise apply the accepted CPU action.
    always_comb begin
        next_state = state;
        bus_op     = BUS_NONE;
        writeback  = 1'b0;
        if (snoop_sel) begin
            next_state = cur;
            case (cur)
                ST_SHARED: begin
                    if (snoop_op == BUS_WR_MISS || snoop_op == BUS_INV)
                        next_state = ST_INVALID;
                end
                ST_EXCLUSIVE: begin
                    if (snoop_op == BUS_RD_MISS) begin
                        next_state = ST_SHARED;
                        writeback  = 1'b1;
                    end else if (snoop_op == BUS_WR_MISS) begin
                        next_state = ST_INVALID;
                        writeback  = 1'b1;
                    end else if (snoop_op == BUS_INV) begin
                        next_state = ST_INVALID;
                    end
                end
                default: ;
            endcase
        end else if (cpu_sel) begin
            next_state = cur;
            case (cur)
                ST_INVALID: begin
                    if (cpu_action == ACT_RD_MISS) begin
                        next_state = ST_SHARED;
                        bus_op     = BUS_RD_MISS;
                    end else if (cpu_action == ACT_WR_MISS) begin
                        next_state = ST_EXCLUSIVE;
                        bus_op     = BUS_WR_MISS;
                    end
                end
                ST_SHARED: begin
                    if (cpu_action == ACT_RD_MISS) begin
                        bus_op = BUS_RD_MISS;
                    end else if (cpu_action == ACT_WR_HIT) begin
                        next_state = ST_EXCLUSIVE;
                        bus_op     = BUS_INV;
                    end else if (cpu_action == ACT_WR_MISS) begin
                        next_state = ST_EXCLUSIVE;
                        bus_op     = BUS_WR_MISS;
                    end
                end
                ST_EXCLUSIVE: begin
                    if (cpu_action == ACT_RD_MISS) begin
                        next_state = ST_SHARED;
                        bus_op     = BUS_RD_MISS;
                        writeback  = 1'b1;
                    end else if (cpu_action == ACT_WR_MISS) begin
                        bus_op    = BUS_WR_MISS;
                        writeback = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/coherence_ctrl_array.sv
// Per-line MSI snooping controller: state array, bus request handshake
// and writeback pulse generation with a one-entry CPU holding slot.
module coherence_ctrl_array
    import coherence_pkg::*;
#(
    parameter int         NUM_LINES  = 4,
    parameter int         IDX_W      = $clog2(NUM_LINES),
    parameter logic [1:0] INIT_STATE = 2'b00
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_valid,
    output logic                   cpu_ready,
    input  logic [2:0]             cpu_action,
    input  logic [IDX_W-1:0]       cpu_index,
    input  logic                   snoop_valid,
    input  logic [2:0]             snoop_op,
    input  logic [IDX_W-1:0]       snoop_index,
    output logic                   bus_valid,
    output logic [2:0]             bus_op,
    output logic [IDX_W-1:0]       bus_index,
    input  logic                   bus_grant,
    output logic                   writeback_block,
    output logic [IDX_W-1:0]       writeback_index,
    output logic [2*NUM_LINES-1:0] line_state
);

    logic [1:0]           line_q [NUM_LINES];
    logic [1:0]           line_d [NUM_LINES];
    logic [2:0]           op_d   [NUM_LINES];
    logic [NUM_LINES-1:0] wb_d;
    logic                 accept;
    logic                 cpu_wb;
    logic                 snoop_wb;
    logic [2:0]           new_op;
    logic                 hold_valid;
    logic [IDX_W-1:0]     hold_index;

    assign cpu_ready = !bus_valid && !(snoop_valid && snoop_index == cpu_index);
    assign accept    = cpu_valid && cpu_ready;
    assign new_op    = op_d[cpu_index];
    assign cpu_wb    = accept && wb_d[cpu_index];
    assign snoop_wb  = snoop_valid && wb_d[snoop_index];

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        coherence_next_state u_ns (
            .state      (line_q[gi]),
            .cpu_sel    (accept && cpu_index == IDX_W'(gi)),
            .cpu_action (cpu_action),
            .snoop_sel  (snoop_valid && snoop_index == IDX_W'(gi)),
            .snoop_op   (snoop_op),
            .next_state (line_d[gi]),
            .bus_op     (op_d[gi]),
            .writeback  (wb_d[gi])
        );
        assign line_state[2*gi +: 2] = line_q[gi];
    end

    // Line state array.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LINES; i++) begin
            if (reset) line_q[i] <= INIT_STATE;
            else       line_q[i] <= line_d[i];
        end
    end

    // Bus message register: loaded on a CPU acceptance, held until granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus_valid <= 1'b0;
            bus_op    <= BUS_NONE;
            bus_index <= '0;
        end else if (bus_valid) begin
            if (bus_grant) begin
                bus_valid <= 1'b0;
                bus_op    <= BUS_NONE;
            end
        end else if (accept && new_op != BUS_NONE) begin
            bus_valid <= 1'b1;
            bus_op    <= new_op;
            bus_index <= cpu_index;
        end
    end

    // Writeback pulse: snoop first, then a held CPU writeback, then a new one.
    always_ff @(posedge clock) begin
        if (reset) begin
            writeback_block <= 1'b0;
            writeback_index <= '0;
            hold_valid      <= 1'b0;
            hold_index      <= '0;
        end else if (snoop_wb) begin
            writeback_block <= 1'b1;
            writeback_index <= snoop_index;
            if (cpu_wb) begin
                hold_valid <= 1'b1;
                hold_index <= cpu_index;
            end
        end else if (hold_valid) begin
            writeback_block <= 1'b1;
            writeback_index <= hold_index;
            hold_valid      <= cpu_wb;
            if (cpu_wb) hold_index <= cpu_index;
        end else if (cpu_wb) begin
            writeback_block <= 1'b1;
            writeback_index <= cpu_index;
        end else begin
            writeback_block <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coherence_ctrl_array.sv
// Directed scoreboard bench for coherence_ctrl_array.
// Bus messages and writebacks are queued when driven and checked on output.
module tb_coherence_ctrl_array;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_valid = 1'b0;
    logic          cpu_ready;
    logic [2:0]    cpu_action = 3'b000;
    logic [IW-1:0] cpu_index = '0;
    logic          snoop_valid = 1'b0;
    logic [2:0]    snoop_op = 3'b000;
    logic [IW-1:0] snoop_index = '0;
    logic          bus_valid;
    logic [2:0]    bus_op;
    logic [IW-1:0] bus_index;
    logic          bus_grant = 1'b0;
    logic          writeback_block;
    logic [IW-1:0] writeback_index;
    logic [2*N-1:0] line_state;

    int total = 0;
    int bad   = 0;

    logic [2:0]    bq_op  [$];
    logic [IW-1:0] bq_idx [$];
    logic [IW-1:0] wq     [$];
    logic [2:0]    m_op;
    logic [IW-1:0] m_idx;

    coherence_ctrl_array #(.NUM_LINES(N), .IDX_W(IW), .INIT_STATE(2'b00)) dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_valid       (cpu_valid),
        .cpu_ready       (cpu_ready),
        .cpu_action      (cpu_action),
        .cpu_index       (cpu_index),
        .snoop_valid     (snoop_valid),
        .snoop_op        (snoop_op),
        .snoop_index     (snoop_index),
        .bus_valid       (bus_valid),
        .bus_op          (bus_op),
        .bus_index       (bus_index),
        .bus_grant       (bus_grant),
        .writeback_block (writeback_block),
        .writeback_index (writeback_index),
        .line_state      (line_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ls(input int i);
        return line_state[2*i +: 2];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one CPU request to completion, granting its bus message if any.
    task automatic cpu_req(input logic [2:0] act, input logic [IW-1:0] idx,
                           input logic [2:0] op);
        cpu_valid  = 1'b1;
        cpu_action = act;
        cpu_index  = idx;
        tick();
        cpu_valid  = 1'b0;
        cpu_action = 3'b000;
        if (op != 3'b000) begin
            bq_op.push_back(op);
            bq_idx.push_back(idx);
            bus_grant = 1'b1;
            tick();
            bus_grant = 1'b0;
        end
    endtask

    // Output-side scoreboard: granted bus messages and writeback pulses.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus_valid && bus_grant) begin
                if (bq_op.size() == 0) begin
                    chk("bus_unexpected", {29'd0, bus_op}, 32'd0);
                end else begin
                    m_op  = bq_op.pop_front();
                    m_idx = bq_idx.pop_front();
                    chk("sb_bus_op", {29'd0, bus_op}, {29'd0, m_op});
                    chk("sb_bus_index", {30'd0, bus_index}, {30'd0, m_idx});
                end
            end
            if (writeback_block) begin
                if (wq.size() == 0) begin
                    chk("wb_unexpected", {30'd0, writeback_index}, 32'hdead);
                end else begin
                    m_idx = wq.pop_front();
                    chk("sb_wb_index", {30'd0, writeback_index}, {30'd0, m_idx});
                end
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_lines", line_state, 0);
        chk("rst_bus_valid", bus_valid, 0);
        chk("rst_bus_op", bus_op, 0);
        chk("rst_bus_index", bus_index, 0);
        chk("rst_wb", writeback_block, 0);
        chk("rst_wb_index", writeback_index, 0);
        reset = 1'b0;
        #1;
        chk("rst_cpu_ready", cpu_ready, 1);

        // Read miss on Invalid line 2
        cpu_valid  = 1'b1;
        cpu_action = 3'b010;
        cpu_index  = 2'd2;
        bq_op.push_back(3'b001);
        bq_idx.push_back(2'd2);
        #1;
        chk("rm_ready", cpu_ready, 1);
        tick();
        cpu_action = 3'b001;
        #1;
        chk("rm_line2", ls(2), 2'b01);
        chk("rm_bus_valid", bus_valid, 1);
        chk("rm_bus_op", bus_op, 3'b001);
        chk("rm_bus_index", bus_index, 2);
        chk("rm_stall0", cpu_ready, 0);
        tick();
        chk("rm_hold_valid", bus_valid, 1);
        chk("rm_stall1", cpu_ready, 0);
        bus_grant = 1'b1;
        #1;
        chk("rm_stall_grant", cpu_ready, 0);
        tick();
        bus_grant = 1'b0;
        cpu_valid = 1'b0;
        chk("rm_after_valid", bus_valid, 0);
        chk("rm_after_op", bus_op, 0);

        // Line 1 Shared, write hit, grant after 3 cycles
        cpu_req(3'b010, 2'd1, 3'b001);
        chk("wh_line1_s", ls(1), 2'b01);
        cpu_valid  = 1'b1;
        cpu_action = 3'b011;
        cpu_index  = 2'd1;
        bq_op.push_back(3'b011);
        bq_idx.push_back(2'd1);
        tick();
        cpu_action = 3'b001;
        cpu_index  = 2'd0;
        chk("wh_line1_e", ls(1), 2'b10);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("wh_op_held", bus_op, 3'b011);
            chk("wh_valid_held", bus_valid, 1);
            chk("wh_stall", cpu_ready, 0);
            tick();
        end
        bus_grant = 1'b1;
        #1;
        chk("wh_stall_grant", cpu_ready, 0);
        tick();
        bus_grant = 1'b0;
        cpu_valid = 1'b0;
        chk("wh_released", bus_valid, 0);
        chk("wh_line0_untouched", ls(0), 2'b00);

        // Line 3 Exclusive, snoop read miss
        cpu_req(3'b100, 2'd3, 3'b010);
        chk("sr_line3_e", ls(3), 2'b10);
        snoop_valid = 1'b1;
        snoop_op    = 3'b001;
        snoop_index = 2'd3;
        wq.push_back(2'd3);
        tick();
        snoop_valid = 1'b0;
        chk("sr_line3_s", ls(3), 2'b01);
        chk("sr_wb", writeback_block, 1);
        chk("sr_wb_index", writeback_index, 3);
        tick();
        chk("sr_wb_done", writeback_block, 0);

        // CPU write miss on Excl line 0 with snoop write miss on Excl line 1
        cpu_req(3'b100, 2'd0, 3'b010);
        chk("cc_line0_e", ls(0), 2'b10);
        cpu_valid   = 1'b1;
        cpu_action  = 3'b100;
        cpu_index   = 2'd0;
        snoop_valid = 1'b1;
        snoop_op    = 3'b010;
        snoop_index = 2'd1;
        bq_op.push_back(3'b010);
        bq_idx.push_back(2'd0);
        wq.push_back(2'd1);
        wq.push_back(2'd0);
        #1;
        chk("cc_ready", cpu_ready, 1);
        tick();
        cpu_valid   = 1'b0;
        snoop_valid = 1'b0;
        chk("cc_wb1", writeback_block, 1);
        chk("cc_wb1_index", writeback_index, 1);
        chk("cc_line0", ls(0), 2'b10);
        chk("cc_line1", ls(1), 2'b00);
        tick();
        chk("cc_wb0", writeback_block, 1);
        chk("cc_wb0_index", writeback_index, 0);
        chk("cc_bus_valid", bus_valid, 1);
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        chk("cc_wb_done", writeback_block, 0);
        chk("cc_bus_done", bus_valid, 0);

        // Write hit and snoop invalidate on Shared line 2
        chk("inv_line2_s", ls(2), 2'b01);
        cpu_valid   = 1'b1;
        cpu_action  = 3'b011;
        cpu_index   = 2'd2;
        snoop_valid = 1'b1;
        snoop_op    = 3'b011;
        snoop_index = 2'd2;
        #1;
        chk("inv_stall", cpu_ready, 0);
        tick();
        snoop_valid = 1'b0;
        chk("inv_line2_i", ls(2), 2'b00);
        #1;
        chk("inv_retry_ready", cpu_ready, 1);
        tick();
        cpu_valid = 1'b0;
        chk("inv_illegal_state", ls(2), 2'b00);
        chk("inv_no_bus", bus_valid, 0);
        tick();
        chk("inv_no_bus2", bus_valid, 0);

        // Reset while a bus message awaits grant
        cpu_valid  = 1'b1;
        cpu_action = 3'b010;
        cpu_index  = 2'd3;
        bq_op.push_back(3'b001);
        bq_idx.push_back(2'd3);
        tick();
        cpu_valid = 1'b0;
        chk("mr_pending", bus_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(bq_op.pop_back());
        void'(bq_idx.pop_back());
        chk("mr_lines", line_state, 0);
        chk("mr_bus_valid", bus_valid, 0);
        chk("mr_bus_op", bus_op, 0);
        chk("mr_wb", writeback_block, 0);
        tick();
        chk("mr_bus_still_idle", bus_valid, 0);

        chk("bus_queue_empty", bq_op.size(), 0);
        chk("wb_queue_empty", wq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coherence_ctrl_array.md
Name: coherence_ctrl_array

Overview:
- Per-line MSI snooping coherence controller for a direct-indexed cache of NUM_LINES lines.
- Each line holds its own Invalid/Shared/Exclusive state.
- Serves CPU requests, placing read-miss, write-miss and invalidate messages on the shared bus with a grant handshake.
- Reacts to snooped bus traffic from other caches: downgrades, invalidates and writes back.
- Sits between the cache datapath and the snooping bus arbiter.

Parameters:
- NUM_LINES, 4, number of tracked cache lines (power of two, ≥2).
- IDX_W, $clog2(NUM_LINES), line index width.
- INIT_STATE, 2'b00, state loaded into every line on reset.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_valid  in  1  CPU request present.
- cpu_ready  out  1  request accepted this cycle when cpu_valid && cpu_ready.
- cpu_action  in  3  000 none, 001 read hit, 010 read miss, 011 write hit, 100 write miss.
- cpu_index  in  IDX_W  target line.
- snoop_valid  in  1  bus message from another cache.
- snoop_op  in  3  001 read miss, 010 write miss, 011 invalidate.
- snoop_index  in  IDX_W  snooped line.
- bus_valid  out  1  bus message pending.
- bus_op  out  3  000 none, 001 read miss, 010 write miss, 011 invalidate.
- bus_index  out  IDX_W  line of pending message.
- bus_grant  in  1  arbiter accepts bus message.
- writeback_block  out  1  one-cycle pulse: Exclusive line must be written back.
- writeback_index  out  IDX_W  line being written back.
- line_state  out  2*NUM_LINES  packed states, line i at [2i+1:2i].

Behaviour:
- State encoding: 00 Invalid, 01 Shared, 10 Exclusive. 11 is illegal; treat it as Invalid on the next update.
- Reset (synchronous): every line set to INIT_STATE. bus_valid=0, bus_op=000, bus_index=0, writeback_block=0, writeback_index=0. Reset mid-handshake drops the pending bus message.
- cpu_ready = !bus_valid && !(snoop_valid && snoop_index==cpu_index).
- CPU transitions on acceptance. Line state updates at that edge; bus_valid/bus_op/bus_index are registered and appear one cycle later.
  - Invalid: read miss → Shared, bus 001. Write miss → Exclusive, bus 010. Read hit / write hit are illegal: no change, no bus message.
  - Shared: read hit → Shared, none. Read miss → Shared, bus 001. Write hit → Exclusive, bus 011. Write miss → Exclusive, bus 010.
  - Exclusive: read hit → Exclusive, none. Write hit → Exclusive, none. Read miss → Shared, bus 001, writeback. Write miss → Exclusive, bus 010, writeback.
  - Action 000 → nothing.
- Bus handshake: bus_valid, bus_op and bus_index are held stable until the cycle bus_grant=1. On the next edge bus_valid=0 and bus_op=000. bus_grant while bus_valid=0 is ignored.
- Snoop transitions take effect at the edge where snoop_valid=1, regardless of the CPU handshake.
  - Shared: read miss → Shared. Write miss or invalidate → Invalid.
  - Exclusive: read miss → Shared with writeback. Write miss → Invalid with writeback. Invalidate → Invalid, no writeback (protocol error, tolerated).
  - Invalid: no change.
- Writeback: writeback_block is a registered pulse the cycle after its cause, with writeback_index set to the cause's line.
  - A CPU-caused and a snoop-caused writeback in the same cycle: snoop wins the pulse.
  - The CPU writeback is pulsed the following cycle; a 1-entry holding register covers this.
- Same-cycle CPU and snoop on different indices: both apply.
- Same index: snoop applies, CPU is stalled (cpu_ready=0) and re-evaluated next cycle against the new state.
- line_state reflects register contents (post-edge), with no combinational path from inputs.

Decomposition:
- Package coherence_pkg holds:
  - state constants ST_INVALID, ST_SHARED, ST_EXCLUSIVE;
  - CPU action constants ACT_NONE, ACT_RD_HIT, ACT_RD_MISS, ACT_WR_HIT, ACT_WR_MISS;
  - bus op constants BUS_NONE, BUS_RD_MISS, BUS_WR_MISS, BUS_INV.
- One sub-module, coherence_next_state: purely combinational. Inputs are current state, CPU action and snoop op with their selects; outputs are next state, bus op and writeback flag.
- The top instantiates the state array, the handshake registers and the writeback holding register.

Test Plan:
- Reset with INIT_STATE=00, then accept CPU read miss on index 2 → line_state[5:4]=01; next cycle bus_valid=1, bus_op=001, bus_index=2; cpu_ready=0 until bus_grant, bus_valid=0 the cycle after grant.
- Line 1 Shared, CPU write hit, grant after 3 cycles → line 1=10, bus_op=011 held for all 3 cycles, a second cpu_valid is stalled throughout.
- Line 3 Exclusive, snoop read miss index 3 → line 3=01, writeback_block=1 with writeback_index=3 for exactly one cycle.
- Same cycle: CPU write miss on Exclusive line 0, snoop write miss on Exclusive line 1 → writeback pulse index 1, then index 0 next cycle; line 0=10, line 1=00.
- Same cycle: CPU write hit and snoop invalidate on Shared line 2 → cpu_ready=0, line 2=00; next cycle CPU write hit is illegal on Invalid: no bus message, state 00.
- Assert reset while bus_valid=1 awaiting grant → next cycle all lines INIT_STATE, bus_valid=0, writeback_block=0.
